// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0-T2) and execute (T3-T6) microsteps that produce datapath strobes.
// Define CTRL_SEQ_MULDIV_EN to enable the MUL/DIV sequences; when it is undefined, those opcodes decode as illegal.
module control_sequencer #(
  parameter int OPW = 5
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] IR,
  input  logic        mem_ready,
  output logic [29:0] ctl,
  output logic        run,
  output logic        illegal
);

  typedef enum logic [3:0] {RST, T0, T1, T2, T3, T4, T5, T6, HALTED} state_t;

  localparam int PC_OUT    = 0;
  localparam int ZLOW_OUT  = 1;
  localparam int MDR_OUT   = 3;
  localparam int MAR_IN    = 7;
  localparam int PC_IN     = 8;
  localparam int MDR_IN    = 9;
  localparam int IR_IN     = 10;
  localparam int Y_IN      = 11;
  localparam int INC_PC    = 12;
  localparam int Z_IN      = 15;
  localparam int GRA       = 16;
  localparam int GRB       = 17;
  localparam int GRC       = 18;
  localparam int R_IN      = 19;
  localparam int R_OUT     = 20;
  localparam int ADD_B     = 22;
  localparam int SUB_B     = 23;
  localparam int AND_B     = 26;
  localparam int OR_B      = 27;
  localparam int READ_B    = 28;

  localparam logic [OPW-1:0] OP_ADD  = OPW'(5'b00011);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(5'b00100);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5'b00101);
  localparam logic [OPW-1:0] OP_OR   = OPW'(5'b00110);
  localparam logic [OPW-1:0] OP_JR   = OPW'(5'b10100);
  localparam logic [OPW-1:0] OP_JAL  = OPW'(5'b10101);
  localparam logic [OPW-1:0] OP_NOP  = OPW'(5'b11010);
  localparam logic [OPW-1:0] OP_HALT = OPW'(5'b11011);

`ifdef CTRL_SEQ_MULDIV_EN
  localparam int ZHIGH_OUT = 2;
  localparam int HI_IN     = 13;
  localparam int LO_IN     = 14;
  localparam int MUL_B     = 24;
  localparam int DIV_B     = 25;
  localparam logic [OPW-1:0] OP_MUL = OPW'(5'b01110);
  localparam logic [OPW-1:0] OP_DIV = OPW'(5'b01111);
`endif

  state_t state_reg, state_next;

  logic [OPW-1:0] opcode;
  logic           unused_ir;
  logic           is_alu, is_muldiv, is_jr, is_jal, is_nop, is_halt;

  assign opcode    = IR[31 -: OPW];
  assign unused_ir = ^IR[31-OPW:0];

  assign is_alu  = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                   (opcode == OP_AND) || (opcode == OP_OR);
  assign is_jr   = (opcode == OP_JR);
  assign is_jal  = (opcode == OP_JAL);
  assign is_nop  = (opcode == OP_NOP);
  assign is_halt = (opcode == OP_HALT);
`ifdef CTRL_SEQ_MULDIV_EN
  assign is_muldiv = (opcode == OP_MUL) || (opcode == OP_DIV);
`else
  assign is_muldiv = 1'b0;
`endif

  always_ff @(posedge clk or posedge clr) begin
    if (clr) state_reg <= RST;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RST:    state_next = T0;
      T0:     state_next = T1;
      T1:     if (mem_ready) state_next = T2;
      T2:     state_next = T3;
      T3: begin
        if (is_alu || is_muldiv || is_jal) state_next = T4;
        else if (is_halt)                  state_next = HALTED;
        else                               state_next = T0;
      end
      T4:     state_next = (is_alu || is_muldiv) ? T5 : T0;
      T5:     state_next = is_muldiv ? T6 : T0;
      T6:     state_next = T0;
      HALTED: state_next = HALTED;
      default: state_next = RST;
    endcase
  end

  // Decoded from the live state and IR rather than registered: IR is loaded at the
  // T2->T3 edge, so a registered decode would see the previous instruction in T3.
  always_comb begin
    ctl     = '0;
    illegal = 1'b0;
    run     = (state_reg != RST) && (state_reg != HALTED);
    case (state_reg)
      T0: begin
        ctl[PC_OUT] = 1'b1; ctl[MAR_IN] = 1'b1; ctl[INC_PC] = 1'b1; ctl[Z_IN] = 1'b1;
      end
      T1: begin
        ctl[ZLOW_OUT] = 1'b1; ctl[PC_IN] = 1'b1; ctl[READ_B] = 1'b1; ctl[MDR_IN] = 1'b1;
      end
      T2: begin
        ctl[MDR_OUT] = 1'b1; ctl[IR_IN] = 1'b1;
      end
      T3: begin
        if (is_alu) begin
          ctl[GRB] = 1'b1; ctl[R_OUT] = 1'b1; ctl[Y_IN] = 1'b1;
        end else if (is_muldiv) begin
          ctl[GRA] = 1'b1; ctl[R_OUT] = 1'b1; ctl[Y_IN] = 1'b1;
        end else if (is_jr) begin
          ctl[GRA] = 1'b1; ctl[R_OUT] = 1'b1; ctl[PC_IN] = 1'b1;
        end else if (is_jal) begin
          ctl[PC_OUT] = 1'b1; ctl[GRB] = 1'b1; ctl[R_IN] = 1'b1;
        end else begin
          illegal = !(is_nop || is_halt);
        end
      end
      T4: begin
        if (is_alu) begin
          ctl[GRC] = 1'b1; ctl[R_OUT] = 1'b1; ctl[Z_IN] = 1'b1;
          ctl[ADD_B] = (opcode == OP_ADD);
          ctl[SUB_B] = (opcode == OP_SUB);
          ctl[AND_B] = (opcode == OP_AND);
          ctl[OR_B]  = (opcode == OP_OR);
        end else if (is_jal) begin
          ctl[GRA] = 1'b1; ctl[R_OUT] = 1'b1; ctl[PC_IN] = 1'b1;
        end
`ifdef CTRL_SEQ_MULDIV_EN
        else if (is_muldiv) begin
          ctl[GRB] = 1'b1; ctl[R_OUT] = 1'b1; ctl[Z_IN] = 1'b1;
          ctl[MUL_B] = (opcode == OP_MUL);
          ctl[DIV_B] = (opcode == OP_DIV);
        end
`endif
      end
      T5: begin
        if (is_alu) begin
          ctl[ZLOW_OUT] = 1'b1; ctl[GRA] = 1'b1; ctl[R_IN] = 1'b1;
        end
`ifdef CTRL_SEQ_MULDIV_EN
        else if (is_muldiv) begin
          ctl[ZLOW_OUT] = 1'b1; ctl[LO_IN] = 1'b1;
        end
`endif
      end
      T6: begin
`ifdef CTRL_SEQ_MULDIV_EN
        ctl[ZHIGH_OUT] = 1'b1; ctl[HI_IN] = 1'b1;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a table-driven instruction model plans the expected strobes for every
// cycle, a negedge process compares the DUT against that plan, and a few literal words pin the model.
module tb_control_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] IR;
  logic        mem_ready;
  logic [29:0] ctl;
  logic        run;
  logic        illegal;

  int vectors = 0;
  int miscompares = 0;

  control_sequencer dut (
    .clk(clk), .clr(clr), .IR(IR), .mem_ready(mem_ready),
    .ctl(ctl), .run(run), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] ir;
    logic        cl;
    logic        mr;
    logic [29:0] ctl;
    logic        run;
    logic        ill;
    logic        lit_en;
    logic [29:0] lit;
  } cyc_t;

  cyc_t plan[$];
  cyc_t exp_q[$];

  function automatic logic [29:0] bw(input int a = -1, input int b = -1,
                                     input int c = -1, input int d = -1);
    logic [29:0] w;
    w = '0;
    if (a >= 0) w = w | (30'd1 << a);
    if (b >= 0) w = w | (30'd1 << b);
    if (c >= 0) w = w | (30'd1 << c);
    if (d >= 0) w = w | (30'd1 << d);
    return w;
  endfunction

  task automatic add(input logic [31:0] ir, input logic cl, input logic mr,
                     input logic [29:0] c, input logic r, input logic il);
    cyc_t e;
    e.ir = ir; e.cl = cl; e.mr = mr; e.ctl = c; e.run = r; e.ill = il;
    e.lit_en = 1'b0; e.lit = '0;
    plan.push_back(e);
  endtask

  task automatic pin(input int idx, input logic [29:0] v);
    cyc_t e;
    e = plan[idx];
    e.lit_en = 1'b1;
    e.lit = v;
    plan[idx] = e;
  endtask

  task automatic reset_seq(input int n);
    for (int i = 0; i < n; i++) add(32'h0, 1'b1, 1'b1, '0, 1'b0, 1'b0);
    add(32'h0, 1'b0, 1'b1, '0, 1'b0, 1'b0);
  endtask

  task automatic halted_seq(input logic [31:0] ir, input int n);
    for (int i = 0; i < n; i++) add(ir, 1'b0, i[0], '0, 1'b0, 1'b0);
  endtask

  // Expected per-cycle behaviour of one instruction, straight from its microstep table.
  task automatic expect_instr(input logic [31:0] ir, input int waits, input logic mo);
    logic [4:0] op;
    op = ir[31:27];
    $display("plan ir=%h op=%b waits=%0d", ir, op, waits);
    add(ir, 1'b0, mo, bw(0, 7, 12, 15), 1'b1, 1'b0);
    for (int i = 0; i < waits; i++) add(ir, 1'b0, 1'b0, bw(1, 8, 9, 28), 1'b1, 1'b0);
    add(ir, 1'b0, 1'b1, bw(1, 8, 9, 28), 1'b1, 1'b0);
    add(ir, 1'b0, mo, bw(3, 10), 1'b1, 1'b0);
    case (op)
      5'b00011, 5'b00100, 5'b00101, 5'b00110: begin
        int ob;
        ob = (op == 5'b00011) ? 22 : (op == 5'b00100) ? 23 : (op == 5'b00101) ? 26 : 27;
        add(ir, 1'b0, mo, bw(11, 17, 20), 1'b1, 1'b0);
        add(ir, 1'b0, mo, bw(15, 18, 20, ob), 1'b1, 1'b0);
        add(ir, 1'b0, mo, bw(1, 16, 19), 1'b1, 1'b0);
      end
`ifdef CTRL_SEQ_MULDIV_EN
      5'b01110, 5'b01111: begin
        add(ir, 1'b0, mo, bw(11, 16, 20), 1'b1, 1'b0);
        add(ir, 1'b0, mo, bw(15, 17, 20, (op == 5'b01110) ? 24 : 25), 1'b1, 1'b0);
        add(ir, 1'b0, mo, bw(1, 14), 1'b1, 1'b0);
        add(ir, 1'b0, mo, bw(2, 13), 1'b1, 1'b0);
      end
`endif
      5'b10100: add(ir, 1'b0, mo, bw(8, 16, 20), 1'b1, 1'b0);
      5'b10101: begin
        add(ir, 1'b0, mo, bw(0, 17, 19), 1'b1, 1'b0);
        add(ir, 1'b0, mo, bw(8, 16, 20), 1'b1, 1'b0);
      end
      5'b11010, 5'b11011: add(ir, 1'b0, mo, '0, 1'b1, 1'b0);
      default: add(ir, 1'b0, mo, '0, 1'b1, 1'b1);
    endcase
  endtask

  task automatic execute();
    cyc_t e;
    while (plan.size() > 0) begin
      e = plan.pop_front();
      @(posedge clk);
      #1;
      IR = e.ir;
      clr = e.cl;
      mem_ready = e.mr;
      exp_q.push_back(e);
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, want);
    end
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cyc_t e;
      e = exp_q.pop_front();
      vectors++;
      if (ctl !== e.ctl || run !== e.run || illegal !== e.ill) begin
        miscompares++;
        $display("FAIL cycle ir=%h: ctl %h want %h, run %b want %b, illegal %b want %b",
                 e.ir, ctl, e.ctl, run, e.run, illegal, e.ill);
      end
      if (e.lit_en) begin
        vectors++;
        if (ctl !== e.lit) begin
          miscompares++;
          $display("FAIL literal ir=%h: ctl %h want %h", e.ir, ctl, e.lit);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    logic [31:0] mul_ir;
    logic [29:0] t4_word;
    clr = 1'b1;
    mem_ready = 1'b1;
    IR = 32'h0;

    reset_seq(2);
    base = plan.size();
    expect_instr(32'h1800_0000, 0, 1'b1);
    pin(base, 30'h000_9081);
    pin(base + 3, 30'h012_0800);
    pin(base + 4, 30'h054_8000);
    pin(base + 5, 30'h009_0002);
    expect_instr(32'h1800_0000, 3, 1'b0);
    expect_instr(32'h2000_ABCD, 1, 1'b0);
    expect_instr(32'h2800_0000, 0, 1'b1);
    expect_instr(32'h3000_0F0F, 2, 1'b0);
    base = plan.size();
    expect_instr(32'hA000_0000, 0, 1'b1);
    pin(base + 3, 30'h011_0100);
    base = plan.size();
    expect_instr(32'hA800_0000, 0, 1'b0);
    pin(base + 3, 30'h00A_0001);
    pin(base + 4, 30'h011_0100);
    expect_instr(32'hD000_0000, 0, 1'b1);
    expect_instr(32'hF800_0000, 0, 1'b0);
    expect_instr(32'h0000_0000, 1, 1'b1);
    expect_instr(32'h7000_0000, 0, 1'b1);
    expect_instr(32'h7800_1234, 0, 1'b0);
    expect_instr(32'hD800_0000, 0, 1'b1);
    halted_seq(32'hD800_0000, 6);
    reset_seq(1);

`ifdef CTRL_SEQ_MULDIV_EN
    mul_ir = 32'h7000_0000;
    t4_word = 30'h112_8000;
`else
    mul_ir = 32'h1800_0000;
    t4_word = 30'h054_8000;
`endif
    base = plan.size();
    expect_instr(mul_ir, 1, 1'b1);
    while (plan.size() > base + 5) void'(plan.pop_back());
    execute();

    // Mid-T4: strobes must vanish as soon as clr rises, well before the next edge.
    @(posedge clk);
    #1;
    check_lit("t4 before clr", {2'b0, ctl}, {2'b0, t4_word});
    #2;
    clr = 1'b1;
    #1;
    check_lit("ctl under async clr", {2'b0, ctl}, 32'h0);
    check_lit("run/illegal under async clr", {30'b0, run, illegal}, 32'h0);
    $display("async clr applied mid-T4 ir=%h", mul_ir);

    reset_seq(1);
    expect_instr(32'h7000_0000, 0, 1'b1);
    expect_instr(32'hD000_0000, 0, 1'b1);
    execute();
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
